// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR tap engine: state encoding,
// default sizing and the accumulator width rule.
package fir_pkg;

    localparam int TAPS_DEF   = 8;
    localparam int DATA_W_DEF = 64;
    localparam int PROD_W_DEF = 2 * DATA_W_DEF;

    typedef logic [1:0] fir_state_t;

    localparam fir_state_t ST_IDLE = 2'd0;
    localparam fir_state_t ST_MAC  = 2'd1;
    localparam fir_state_t ST_OUT  = 2'd2;

    // One guard bit per doubling of the tap count keeps the sum exact.
    function automatic int acc_width(input int prod_w, input int taps);
        return prod_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_tap_store.sv
// Sample delay line and coefficient bank with a single indexed read port
// feeding the external multiplier.
module fir_tap_store
    import fir_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en,
    input  logic [DATA_W-1:0]        shift_data,
    input  logic                     flush_en,
    input  logic                     wr_en,
    input  logic [$clog2(TAPS)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(TAPS)-1:0]  rd_addr,
    output logic [DATA_W-1:0]        rd_x,
    output logic [DATA_W-1:0]        rd_h
);

    logic [DATA_W-1:0] x [TAPS];
    logic [DATA_W-1:0] h [TAPS];

    // A flush coinciding with a shift clears the old history first, so only
    // the new sample survives in x[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
            end
        end else if (shift_en || flush_en) begin
            x[0] <= shift_en ? shift_data : '0;
            for (int k = 1; k < TAPS; k++) begin
                x[k] <= (shift_en && !flush_en) ? x[k-1] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                h[k] <= '0;
            end
        end else if (wr_en) begin
            h[wr_addr] <= wr_data;
        end
    end

    assign rd_x = rd_en ? x[rd_addr] : '0;
    assign rd_h = rd_en ? h[rd_addr] : '0;

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one tap per cycle through an external multiplier,
// registered product, exact-width accumulation, one output per sample.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PROD_W = 2 * DATA_W,
    parameter int ACC_W  = acc_width(2 * DATA_W, TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     coef_wr_en,
    output logic                     coef_wr_ready,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [DATA_W-1:0]        coef_data,
    input  logic                     flush,
    output logic [DATA_W-1:0]        mul_a,
    output logic [DATA_W-1:0]        mul_b,
    input  logic [PROD_W-1:0]        mul_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data
);

    localparam int IW = $clog2(TAPS);
    localparam logic [IW:0] LAST_IDX = (IW + 1)'(TAPS);
    localparam logic [IW:0] IDX_ONE  = (IW + 1)'(1);

    fir_state_t        state;
    logic [IW:0]       idx;
    logic [PROD_W-1:0] p_reg;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W-1:0]  acc_next;
    logic              idle;
    logic              accept;
    logic              rd_en;

    assign idle          = (state == ST_IDLE);
    assign in_ready      = idle;
    assign coef_wr_ready = idle;
    assign accept        = in_valid && idle;
    assign rd_en         = (state == ST_MAC) && (idx < LAST_IDX);

    assign p_ext    = {{(ACC_W - PROD_W){p_reg[PROD_W-1]}}, p_reg};
    assign acc_next = acc + p_ext;

    fir_tap_store #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) u_tap_store (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (accept),
        .shift_data (in_data),
        .flush_en   (flush && idle),
        .wr_en      (coef_wr_en && idle),
        .wr_addr    (coef_addr),
        .wr_data    (coef_data),
        .rd_en      (rd_en),
        .rd_addr    (idx[IW-1:0]),
        .rd_x       (mul_a),
        .rd_h       (mul_b)
    );

    // The product is registered, so each accumulate lags its multiply by one
    // cycle; idx runs one step past the last tap to absorb that lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            p_reg     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (idx < LAST_IDX) begin
                        p_reg <= mul_p;
                    end
                    if (idx != '0) begin
                        acc <= acc_next;
                    end
                    if (idx == LAST_IDX) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed plus randomized bench for fir_serial_mac against a sum-of-products
// reference model; the multiplier is modelled combinationally here.
module tb_fir_serial_mac;
    import fir_pkg::*;

    localparam int TAPS   = 8;
    localparam int DATA_W = 64;
    localparam int PROD_W = 128;
    localparam int ACC_W  = 131;
    localparam int IW     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              coef_wr_en = 1'b0;
    logic              coef_wr_ready;
    logic [IW-1:0]     coef_addr = '0;
    logic [DATA_W-1:0] coef_data = '0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [PROD_W-1:0] mul_p;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;

    logic [PROD_W-1:0] ext_a;
    logic [PROD_W-1:0] ext_b;

    logic [DATA_W-1:0] mx [TAPS];
    logic [DATA_W-1:0] mh [TAPS];
    logic [ACC_W-1:0]  lastDut;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Stand-in for the external Booth multiplier: full signed 64x64 product.
    assign ext_a = {{DATA_W{mul_a[DATA_W-1]}}, mul_a};
    assign ext_b = {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
    assign mul_p = ext_a * ext_b;

    fir_serial_mac #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_ready (coef_wr_ready),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .flush         (flush),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_p         (mul_p),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data)
    );

    // y = sum over k of x[k]*h[k], done at full output width.
    function automatic logic [ACC_W-1:0] modelOut();
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] b;
        s = '0;
        for (int k = 0; k < TAPS; k++) begin
            a = {{(ACC_W-DATA_W){mx[k][DATA_W-1]}}, mx[k]};
            b = {{(ACC_W-DATA_W){mh[k][DATA_W-1]}}, mh[k]};
            s = s + a * b;
        end
        return s;
    endfunction

    task automatic clearModel();
        for (int k = 0; k < TAPS; k++) begin
            mx[k] = '0;
            mh[k] = '0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [ACC_W-1:0] observed,
                               input logic [ACC_W-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic writeCoef(input logic [IW-1:0] a, input logic [DATA_W-1:0] d);
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_data  = d;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        mh[a] = d;
    endtask

    // Offer one sample (optionally with flush and a same-edge coef write),
    // wait for its result, check latency/value, optionally stall, then drain.
    task automatic applyStimulus(input logic [DATA_W-1:0] sample, input logic fl,
                                 input logic wr, input logic [IW-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input int hold);
        logic [ACC_W-1:0] expected;
        int lat;
        bit seen;
        checkBit("in_ready_before_accept", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_data    = sample;
        flush      = fl;
        coef_wr_en = wr;
        coef_addr  = wa;
        coef_data  = wd;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        flush      = 1'b0;
        coef_wr_en = 1'b0;
        if (wr) mh[wa] = wd;
        if (fl) begin
            for (int k = 0; k < TAPS; k++) mx[k] = '0;
        end
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = sample;
        expected = modelOut();
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                lat  = i;
            end
        end
        checkOutput("out_latency", ACC_W'(lat), ACC_W'(TAPS + 1));
        lastDut = out_data;
        if (seen) begin
            checkOutput("out_data", out_data, expected);
            for (int j = 0; j < hold; j++) begin
                coef_wr_en = 1'b1;
                coef_addr  = '0;
                coef_data  = 64'd99;
                checkBit("coef_wr_ready_out", coef_wr_ready, 1'b0);
                @(posedge clk);
                #1;
                checkBit("hold_out_valid", out_valid, 1'b1);
                checkOutput("hold_out_data", out_data, expected);
                checkBit("hold_in_ready", in_ready, 1'b0);
            end
            coef_wr_en = 1'b0;
            out_ready  = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkBit("post_hs_out_valid", out_valid, 1'b0);
            checkBit("post_hs_in_ready", in_ready, 1'b1);
            checkOutput("post_hs_out_data_kept", out_data, expected);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] minVal;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rc;
        bit sawValid;

        clearModel();
        minVal = {1'b1, {(DATA_W-1){1'b0}}};

        // Reset state
        #3;
        checkBit("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_data", out_data, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkBit("rel_in_ready", in_ready, 1'b1);
        checkBit("rel_coef_wr_ready", coef_wr_ready, 1'b1);
        checkBit("rel_out_valid", out_valid, 1'b0);
        checkOutput("rel_out_data", out_data, '0);
        checkOutput("rel_mul_a", ACC_W'(mul_a), '0);

        // Impulse response
        $display("[TB] impulse response");
        for (int k = 0; k < TAPS; k++) writeCoef(IW'(k), DATA_W'(k + 1));
        for (int n = 0; n <= TAPS; n++) begin
            applyStimulus((n == 0) ? 64'd1 : 64'd0, 1'b0, 1'b0, '0, '0, 0);
            checkOutput("impulse_const", lastDut, (n < TAPS) ? ACC_W'(n + 1) : '0);
        end

        // Sign extension
        $display("[TB] sign handling");
        for (int k = 1; k < TAPS; k++) writeCoef(IW'(k), '0);
        writeCoef('0, -64'sd3);
        applyStimulus(64'd5, 1'b1, 1'b0, '0, '0, 0);
        checkOutput("neg15_const", lastDut, -131'sd15);

        // Extremes
        $display("[TB] extremes");
        for (int k = 0; k < TAPS; k++) writeCoef(IW'(k), minVal);
        for (int n = 0; n < TAPS; n++) applyStimulus(minVal, 1'b0, 1'b0, '0, '0, 0);
        checkOutput("extreme_const", lastDut, ACC_W'(1) << 129);

        // Backpressure; the write offered during OUT must be dropped
        $display("[TB] backpressure");
        for (int k = 0; k < TAPS; k++) writeCoef(IW'(k), '0);
        writeCoef('0, 64'd2);
        applyStimulus(64'd7, 1'b1, 1'b0, '0, '0, 5);
        checkOutput("bp_const", lastDut, ACC_W'(14));
        applyStimulus(64'd1, 1'b1, 1'b0, '0, '0, 0);
        checkOutput("dropped_write_const", lastDut, ACC_W'(2));

        // Randomized traffic
        $display("[TB] random");
        for (int k = 0; k < TAPS; k++) writeCoef(IW'(k), {$urandom, $urandom});
        for (int n = 0; n < 16; n++) begin
            rs = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) rs = DATA_W'($signed($urandom_range(0, 20)) - 10);
            applyStimulus(rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                          IW'($urandom_range(0, TAPS - 1)), rc, 0);
        end

        // Reset in the middle of MAC
        $display("[TB] reset mid-MAC");
        in_valid = 1'b1;
        in_data  = 64'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkBit("midrst_out_valid", out_valid, 1'b0);
        checkBit("midrst_in_ready", in_ready, 1'b1);
        checkOutput("midrst_mul_b", ACC_W'(mul_b), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearModel();
        sawValid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1;
        end
        checkBit("midrst_no_output", sawValid, 1'b0);
        for (int n = 0; n <= TAPS; n++) begin
            applyStimulus((n == 0) ? 64'd1 : 64'd0, 1'b0, 1'b0, '0, '0, 0);
            checkOutput("cleared_coef_const", lastDut, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
